// File: rtl/ctrl_seq.sv
// 8085 machine-cycle / T-state sequencer.
// Drives bus strobes and register-block enables from mcyc/tstate and chk_i.
module ctrl_seq #(
  parameter int IENBSIZE = 9,
  parameter int INSTSIZE = 19
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic [INSTSIZE-1:0] chk_i,
  input  logic                ready,
  output logic [IENBSIZE-1:0] ienb,
  output logic                ale,
  output logic                rd_,
  output logic                wr_,
  output logic                io_m,
  output logic                s1,
  output logic                s0,
  output logic [2:0]          mcyc,
  output logic [2:0]          tstate,
  output logic                halted
);

  typedef enum logic [2:0] {
    T1   = 3'd0,
    T2   = 3'd1,
    T3   = 3'd2,
    T4   = 3'd3,
    T5   = 3'd4,
    T6   = 3'd5,
    TW   = 3'd6,
    THLT = 3'd7
  } tstate_t;

  localparam int RRD  = 0;
  localparam int RWR  = 1;
  localparam int COD  = 2;
  localparam int EXT  = 3;
  localparam int PC_  = 4;
  localparam int PD_  = 5;
  localparam int NXT  = 6;
  localparam int ALEB = 7;
  localparam int RD3  = 8;

  tstate_t    r_ts;
  tstate_t    w_ts_nxt;
  logic [2:0] r_mc;
  logic [2:0] w_mc_nxt;

  logic       w_go6;
  logic       w_dad;
  logic       w_hlt;
  logic       w_dio;
  logic [3:0] w_cyc;
  logic [3:0] w_rw;
  logic [3:0] w_cd;
  logic [1:0] w_k;
  logic       w_rw_k;
  logic       w_cd_k;
  logic       w_idle;
  logic       w_more;
  logic       w_unused;

  assign w_go6    = chk_i[0];
  assign w_dad    = chk_i[1];
  assign w_hlt    = chk_i[2];
  assign w_dio    = chk_i[3];
  assign w_cyc    = chk_i[7:4];
  assign w_rw     = chk_i[11:8];
  assign w_cd     = chk_i[15:12];
  assign w_unused = ^chk_i[INSTSIZE-1:16];

  // Mk (k=2..5) uses bit k-2 of the RW/CD/CYC fields.
  assign w_k    = r_mc[1:0] - 2'd1;
  assign w_rw_k = w_rw[w_k];
  assign w_cd_k = w_cd[w_k];
  assign w_idle = w_dad && (r_mc == 3'd1 || r_mc == 3'd2);
  assign w_more = (r_mc != 3'd4) && w_cyc[r_mc[1:0]];

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      r_ts <= T1;
      r_mc <= 3'd0;
    end else begin
      r_ts <= w_ts_nxt;
      r_mc <= w_mc_nxt;
    end
  end

  always_comb begin
    w_ts_nxt = r_ts;
    w_mc_nxt = r_mc;
    unique case (r_ts)
      T1: w_ts_nxt = T2;
      T2: w_ts_nxt = (!ready && !w_idle) ? TW : T3;
      TW: if (ready) w_ts_nxt = T3;
      T3: begin
        if (r_mc == 3'd0) begin
          w_ts_nxt = T4;
        end else if (w_more) begin
          w_mc_nxt = r_mc + 3'd1;
          w_ts_nxt = T1;
        end else begin
          w_mc_nxt = 3'd0;
          w_ts_nxt = w_hlt ? THLT : T1;
        end
      end
      T4: begin
        if (w_go6) begin
          w_ts_nxt = T5;
        end else if (w_cyc != 4'd0) begin
          w_mc_nxt = 3'd1;
          w_ts_nxt = T1;
        end else begin
          w_ts_nxt = w_hlt ? THLT : T1;
        end
      end
      T5: w_ts_nxt = T6;
      T6: begin
        w_ts_nxt = T1;
        w_mc_nxt = w_cyc[0] ? 3'd1 : 3'd0;
      end
      THLT: begin
        w_ts_nxt = THLT;
        w_mc_nxt = 3'd0;
      end
      default: w_ts_nxt = T1;
    endcase
  end

  always_comb begin
    ienb   = '0;
    ale    = 1'b0;
    rd_    = 1'b1;
    wr_    = 1'b1;
    io_m   = 1'b0;
    s1     = 1'b0;
    s0     = 1'b0;
    halted = 1'b0;
    if (r_ts == THLT) begin
      halted = 1'b1;
    end else if (r_mc == 3'd0) begin
      {s1, s0} = 2'b11;
      unique case (r_ts)
        T1: begin
          ale        = 1'b1;
          ienb[ALEB] = 1'b1;
        end
        T2, TW: rd_ = 1'b0;
        T3: begin
          rd_       = 1'b0;
          ienb[COD] = 1'b1;
          ienb[PC_] = 1'b1;
          ienb[RD3] = 1'b1;
        end
        T4: begin
          ienb[RRD] = 1'b1;
          ienb[RWR] = !w_go6 && (w_cyc == 4'd0);
        end
        T5: ienb[EXT] = 1'b1;
        T6: begin
          ienb[EXT] = 1'b1;
          ienb[RWR] = 1'b1;
        end
        default: ;
      endcase
    end else begin
      ienb[NXT] = !r_mc[0];
      io_m      = (r_mc == 3'd2) && w_dio;
      if (w_idle) begin
        ienb[RWR] = (r_ts == T3);
      end else begin
        ienb[PD_] = w_cd_k;
        {s1, s0}  = w_rw_k ? 2'b01 : 2'b10;
        unique case (r_ts)
          T1: begin
            ale        = 1'b1;
            ienb[ALEB] = 1'b1;
          end
          T2, TW: begin
            rd_       = w_rw_k;
            wr_       = !w_rw_k;
            ienb[RRD] = w_rw_k;
          end
          T3: begin
            rd_       = w_rw_k;
            wr_       = !w_rw_k;
            ienb[RRD] = w_rw_k;
            ienb[RWR] = !w_rw_k;
            ienb[PC_] = !w_rw_k && !w_cd_k;
            ienb[RD3] = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign mcyc   = r_mc;
  assign tstate = r_ts;

endmodule

// File: tb/tb_ctrl_seq.sv
// Bench for ctrl_seq: per-instruction expected T-state list built
// from the instruction fields, compared every clock.
module tb_ctrl_seq;

  logic        clk = 1'b0;
  logic        rst_;
  logic [18:0] chk_i;
  logic        ready;
  logic [8:0]  ienb;
  logic        ale, rd_, wr_, io_m, s1, s0, halted;
  logic [2:0]  mcyc, tstate;

  ctrl_seq dut (
    .clk(clk), .rst_(rst_), .chk_i(chk_i), .ready(ready),
    .ienb(ienb), .ale(ale), .rd_(rd_), .wr_(wr_), .io_m(io_m),
    .s1(s1), .s0(s0), .mcyc(mcyc), .tstate(tstate), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [21:0] obs;
  assign obs = {mcyc, tstate, ienb, ale, rd_, wr_, io_m, s1, s0, halted};

  localparam logic [21:0] RESET_V =
    {3'd0, 3'd0, 9'h080, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  typedef struct {
    int mc;
    int ts;
    bit rdy;
  } ent_t;
  ent_t q[$];

  // Expected outputs for machine cycle mc (0=M1), T-state ts.
  function automatic logic [21:0] expv(input int mc, input int ts,
                                       input logic [18:0] c);
    logic [8:0] ie;
    logic al, rd, wr, io, h, rwb, cdb;
    logic [1:0] s;
    ie = '0; al = 0; rd = 1; wr = 1; io = 0; h = 0; s = 2'b00;
    rwb = 0; cdb = 0;
    if (ts == 7) begin
      h = 1;
    end else if (mc == 0) begin
      s = 2'b11;
      case (ts)
        0: begin al = 1; ie = 9'h080; end
        1, 6: rd = 0;
        2: begin rd = 0; ie = 9'h114; end
        3: ie = (!c[0] && c[7:4] == 4'd0) ? 9'h003 : 9'h001;
        4: ie = 9'h008;
        5: ie = 9'h00A;
        default: ;
      endcase
    end else begin
      if (c[1] && mc <= 2) begin
        if (ts == 2) ie[1] = 1;
      end else begin
        rwb = c[7+mc];
        cdb = c[11+mc];
        s = rwb ? 2'b01 : 2'b10;
        ie[5] = cdb;
        case (ts)
          0: begin al = 1; ie[7] = 1; end
          1, 6: if (rwb) begin wr = 0; ie[0] = 1; end else rd = 0;
          2: begin
            ie[8] = 1;
            if (rwb) begin wr = 0; ie[0] = 1; end
            else begin rd = 0; ie[1] = 1; ie[4] = !cdb; end
          end
          default: ;
        endcase
      end
      ie[6] = (mc == 2 || mc == 4);
      io = (mc == 2) && c[3];
    end
    return {3'(mc), 3'(ts), ie, al, rd, wr, io, s, h};
  endfunction

  function automatic int pickw();
    int r;
    r = int'($urandom % 8);
    return (r < 5) ? 0 : (r < 7) ? 1 : 3;
  endfunction

  task automatic push_t2(input int mc, input int w);
    q.push_back('{mc, 1, w == 0});
    for (int j = 0; j < w; j++) q.push_back('{mc, 6, j == w - 1});
  endtask

  task automatic do_reset();
    #2 rst_ = 1'b1;
    #1 check("rst_async", 32'(obs), 32'(RESET_V));
    @(posedge clk);
    @(negedge clk);
    check("rst_hold", 32'(obs), 32'(RESET_V));
    rst_ = 1'b0;
    ready = 1'b1;
  endtask

  // w2: waits at M2/T2 (-1 = random when rnd); returns entry count.
  task automatic run_instr(input logic [18:0] c, input int w2,
                           input bit rnd, input bit rst_mid,
                           output int len);
    int n;
    int w;
    bit go6, dad, hlt;
    go6 = c[0]; dad = c[1]; hlt = c[2];
    n = 0;
    for (int k = 0; k < 4; k++) if (c[4+k] && n == k) n = k + 1;
    q.delete();
    chk_i = c;
    q.push_back('{0, 0, 1'($urandom)});
    push_t2(0, rnd ? pickw() : 0);
    q.push_back('{0, 2, 1'($urandom)});
    q.push_back('{0, 3, 1'($urandom)});
    if (go6) begin
      q.push_back('{0, 4, 1'($urandom)});
      q.push_back('{0, 5, 1'($urandom)});
    end
    for (int m = 1; m <= n; m++) begin
      q.push_back('{m, 0, 1'($urandom)});
      if (dad && m <= 2) begin
        q.push_back('{m, 1, 1'($urandom)});
      end else begin
        if (m == 1 && w2 >= 0) w = w2;
        else w = rnd ? pickw() : 0;
        push_t2(m, w);
      end
      q.push_back('{m, 2, 1'($urandom)});
    end
    len = q.size();
    if (hlt) for (int j = 0; j < 3; j++) q.push_back('{0, 7, 1'($urandom)});
    for (int i = 0; i < q.size(); i++) begin
      check($sformatf("c%05h m%0d t%0d", c, q[i].mc, q[i].ts),
            32'(obs), 32'(expv(q[i].mc, q[i].ts, c)));
      if (rst_mid && q[i].mc == 1 && q[i].ts == 1) begin
        do_reset();
        return;
      end
      ready = q[i].rdy;
      @(posedge clk);
      @(negedge clk);
    end
    if (hlt) do_reset();
  endtask

  initial begin
    int len;
    logic [18:0] c;
    int n;
    bit go6, dad, dio, hlt, rm;
    rst_ = 1'b1;
    ready = 1'b1;
    chk_i = '0;
    repeat (2) @(negedge clk);
    check("reset", 32'(obs), 32'(RESET_V));
    rst_ = 1'b0;

    run_instr(19'h00000, 0, 0, 0, len);
    check("nop_len", len, 4);
    run_instr(19'h00001, 0, 0, 0, len);
    check("inx_len", len, 6);
    run_instr(19'h02230, 0, 0, 0, len);
    check("mvi_len", len, 10);
    run_instr(19'h04470, 2, 0, 0, len);
    check("wait_len", len, 15);
    run_instr(19'h00238, 0, 0, 0, len);
    run_instr(19'h00032, 0, 0, 0, len);
    run_instr(19'h00014, 0, 0, 0, len);
    run_instr(19'h02230, 0, 0, 1, len);
    run_instr(19'h00000, 0, 0, 0, len);

    for (int t = 0; t < 300; t++) begin
      n   = int'($urandom % 5);
      go6 = ($urandom % 4) == 0;
      dad = (n >= 2) && (($urandom % 4) == 0);
      dio = !dad && 1'($urandom);
      hlt = !go6 && (($urandom % 10) == 0);
      rm  = (n >= 1) && !dad && (($urandom % 15) == 0);
      c = 19'($urandom);
      c[0] = go6;
      c[1] = dad;
      c[2] = hlt;
      c[3] = dio;
      c[7:4] = 4'((1 << n) - 1);
      run_instr(c, -1, 1, rm, len);
    end
    check("final", 32'(obs), 32'(expv(0, 0, chk_i)));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ctrl_seq.md
Name: ctrl_seq

Overview:
- Machine-cycle/T-state sequencer for the 8085 core; sits directly upstream of the ALU/register block.
- Consumes that block's decoded instruction-info vector (chk_i) and produces its 9-bit bus/register enable vector (ienb).
- Also drives external bus strobes (ale, rd_, wr_, io_m, s1/s0).
- Handles opcode fetch, memory/code/IO read and write cycles, 6-T extended fetch, DAD idle cycles, READY wait states and HALT.

Parameters:
- IENBSIZE, 9, width of ienb.
- INSTSIZE, 19, width of chk_i.

Ports:
- clk  input  1  system clock
- rst_  input  1  reset, asynchronous, active-high
- chk_i  input  19  instruction info; see Behaviour for bit map
- ready  input  1  memory/IO ready, sampled on the rising edge that ends T2 or TW
- ienb  output  9  enables to the register block
- ale  output  1  address latch enable
- rd_  output  1  read strobe, active low
- wr_  output  1  write strobe, active low
- io_m  output  1  1 = IO cycle
- s1  output  1  status bit 1
- s0  output  1  status bit 0
- mcyc  output  3  current machine cycle, 0 = M1 .. 4 = M5
- tstate  output  3  current T-state: T1=0 .. T6=5, TW=6, THLT=7
- halted  output  1  high in THLT

Behaviour:
- chk_i bit map:
  - 0 GO6, 1 DAD, 2 HLT, 3 DIO.
  - [7:4] CYC: bit k-2 set means machine cycle Mk exists.
  - [11:8] RW: 1 = write cycle.
  - [15:12] CD: 1 = data pointer.
  - 16-18 are ignored.
  - chk_i is valid from T4 of M1 onward and is held stable through the instruction.
- ienb bit map: 0 RRD, 1 RWR, 2 COD, 3 EXT, 4 PC_, 5 PD_, 6 NXT, 7 ALE, 8 3RD.
- Implementation:
  - State is registered (mcyc, tstate).
  - All outputs are combinational decode of state and chk_i; no output depends on ready.
- Reset (async, any time, including mid-cycle):
  - State forced to M1/T1.
  - Outputs: ienb=9'h080, ale=1, rd_=1, wr_=1, io_m=0, s1=1, s0=1, halted=0.
- First rising edge with rst_ low advances to T2.
- M1 (opcode fetch), s1s0=11:
  - T1: ale=1, ienb[ALE]=1.
  - T2: rd_=0.
  - T3: rd_=0, COD=1, PC_=1, 3RD=1.
  - T4:
    - If GO6=0 and CYC=0000: RRD=1, RWR=1, then next is M1/T1, or THLT if HLT.
    - If GO6=0 and CYC≠0000: RRD=1, then next is M2/T1.
    - If GO6=1: RRD=1, then T5.
  - T5: EXT=1.
  - T6: EXT=1, RWR=1, then M2/T1 if CYC[0], else M1/T1.
- Mk, k=2..5:
  - After Mk, go to the next set CYC bit's cycle, or to M1/T1 if none remain (THLT if HLT).
  - CYC bits are contiguous from bit 0.
  - Read cycle (RW=0): s1s0=10.
    - T1: ale=1, ALE=1, PD_=CD.
    - T2: rd_=0, PD_=CD.
    - T3: rd_=0, RWR=1, 3RD=1, PD_=CD; PC_=1 only when CD=0.
  - Write cycle (RW=1): s1s0=01.
    - T1: ale=1, ALE=1, PD_=CD.
    - T2: wr_=0, RRD=1, PD_=CD.
    - T3: wr_=0, RRD=1, 3RD=1, PD_=CD.
  - NXT=1 in M3 and M5, 0 otherwise.
  - io_m=1 in M3 when DIO=1.
- DAD (chk_i[1]=1): M2 and M3 are bus-idle.
  - No ale, rd_ or wr_; s1s0=00.
  - RWR=1 in T3; NXT per above.
- Wait states:
  - At the edge ending T2, ready=0 sends the sequencer to TW; TW holds while ready=0, then goes to T3.
  - TW outputs equal T2 outputs.
  - No wait in M1/T4-T6 or in DAD idle cycles.
- HALT:
  - THLT: s1s0=00, halted=1, ienb=0, strobes inactive, mcyc=0.
  - THLT is exited only by rst_.
- Simultaneous events: rst_ overrides ready and every state transition.

Test Plan:
- NOP (chk_i=0x00000):
  - tstate sequence 0,1,2,3,0.
  - ienb: 0x080 in T1, 0x114 in T3, 0x003 in T4.
  - rd_ low in T2-T3.
- INX (chk_i=0x00001):
  - 6-T fetch; ienb=0x008 in T5, 0x00A in T6.
  - Returns to M1/T1; no M2.
- MVI M (chk_i=0x02230):
  - M2 code read: PC_=1, PD_=0.
  - M3 write: PD_=1, NXT=1, wr_ low T2-T3, RRD=1, s1s0=01.
  - Total 10 clocks.
- Wait: STA-like cycle with ready=0 for 2 clocks at T2 of M2:
  - tstate 1,6,6,2.
  - rd_ stays low throughout; RWR pulses only in T3.
- OUT (chk_i=0x00238): io_m=1 and wr_ low only in M3. DAD (0x00032): M2/M3 show s1s0=00, no strobes, RWR in T3.
- HLT (0x00014): enters THLT after M2 with halted=1. Assert rst_ mid-M2/T2 of any instruction: immediate ienb=0x080, ale=1, mcyc=0, tstate=0.
